enc_64_6_scan: RTL and testbench
================================

ENC_64_6_SCAN -- requirements
Module: enc_64_6_scan

Interface
REQ-001 Parameters: none; vector width fixed at 64 bits, index width fixed at 6 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_vec is offered.
REQ-005 in_ready  output  1  block accepts a vector this cycle.
REQ-006 in_vec  input  64  request vector, bit i = index i present.
REQ-007 out_valid  output  1  out_idx/out_last/out_empty are valid.
REQ-008 out_ready  input  1  consumer takes the current beat.
REQ-009 out_idx  output  6  encoded index of the lowest pending set bit.
REQ-010 out_last  output  1  current beat is the final beat for the captured vector.
REQ-011 out_empty  output  1  captured vector was all-zero (no index present).

Function
REQ-012 Two states SHALL exist: IDLE and SCAN.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is SCAN.
REQ-014 IDLE with in_valid=1: on the clock edge SHALL capture in_vec into a 64-bit pending register and go to SCAN; in_valid=0 stays IDLE.
REQ-015 Latency: first out_valid SHALL assert the cycle after the accepting edge (one cycle).
REQ-016 In SCAN with nonzero pending: out_idx SHALL equal the lowest set bit position of pending; out_empty=0.
REQ-017 out_last SHALL be 1 when pending has exactly one set bit, else 0.
REQ-018 On out_valid && out_ready edge: the bit at out_idx SHALL be cleared in pending; if out_last=1, state SHALL return to IDLE.
REQ-019 Zero vector captured: SCAN SHALL present one beat with out_idx=0, out_empty=1, out_last=1; handshake returns to IDLE.
REQ-020 Backpressure: while out_ready=0, out_idx, out_last, out_empty and pending SHALL hold stable.
REQ-021 in_valid asserted during SCAN SHALL be ignored (in_ready=0); no capture, no state change.
REQ-022 Final beat and new vector SHALL NOT overlap: one IDLE cycle minimum between consecutive vectors.
REQ-023 One beat per set bit; beats SHALL be emitted strictly in ascending index order, indices 0..63, no wrap.
REQ-024 out_idx, out_last, out_empty SHALL be driven combinationally from pending; no other output path from inputs to outputs except via state.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, pending=0, out_valid=0, in_ready=1, out_idx=0, out_last=0, out_empty=0, independent of clk.
REQ-026 Reset during SCAN SHALL discard all remaining beats; no beat SHALL be emitted after release until a new vector is accepted.
REQ-027 First acceptance after reset release SHALL require a rising clk edge with rst_n=1 and in_valid=1.

Structure
REQ-028 Shared package SHALL hold: state enum {IDLE, SCAN}, VEC_W=64, IDX_W=6 constants.
REQ-029 Sub-module enc_4_2 SHALL be used: 4-bit in, 2-bit lowest-set-bit index plus any-set flag; all-zero gives index 0, flag 0.
REQ-030 64-to-6 lowest-bit encoder SHALL be a three-level tree of enc_4_2 (16 leaf, 4 mid, 1 top); level index bits concatenated top:mid:leaf.
REQ-031 Single always block for sequential state; encoder tree purely combinational.

Verification
REQ-032 in_vec=64'h1, out_ready=1 -> one beat idx=0, last=1, empty=0; in_ready returns 1 next cycle.
REQ-033 in_vec=64'h8000_0000_0000_0001 -> beats idx=0 last=0, then idx=63 last=1.
REQ-034 in_vec=0 -> one beat idx=0, empty=1, last=1.
REQ-035 in_vec=all ones, out_ready toggling every cycle -> 64 beats idx 0..63 ascending, outputs stable while out_ready=0, last only on idx 63.
REQ-036 in_vec=64'hF0, rst_n pulsed low after 2 beats accepted (idx 4,5) -> out_valid=0 asynchronously, in_ready=1; no idx 6/7 after release.
REQ-037 in_vec=64'h3 accepted, second vector 64'h10 held on in_valid during SCAN -> second accepted only in IDLE after idx 1 last; then single beat idx=4.

Source files
------------

// File: rtl/enc_64_6_scan_pkg.sv
// rtl/enc_64_6_scan_pkg.sv - shared types and widths for the 64-to-6 lowest-bit scan encoder
package enc_64_6_scan_pkg;

   localparam int VEC_W = 64;
   localparam int IDX_W = 6;

   // IDLE accepts a new vector, SCAN emits one beat per set bit
   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/enc_64_6_scan_if.sv
// rtl/enc_64_6_scan_if.sv - vector-in / index-beat-out handshake bundle
interface enc_64_6_scan_if;
   import enc_64_6_scan_pkg::*;

   // vector input side
   logic             in_valid;
   logic             in_ready;
   logic [VEC_W-1:0] in_vec;

   // index beat output side
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_empty;

   // the encoder block
   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_idx, out_last, out_empty
   );

   // the producer/consumer driving the encoder
   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_idx, out_last, out_empty
   );

endinterface

// File: rtl/enc_4_2.sv
// rtl/enc_4_2.sv - 4-bit lowest-set-bit encoder with any-set flag
module enc_4_2 (
   input  logic [3:0] vec,
   output logic [1:0] idx,
   output logic       any
);

   // lowest set bit wins; all-zero reports index 0 with any=0
   always_comb begin
      idx = 2'd0;
      any = |vec;
      casez (vec)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

endmodule

// File: rtl/enc_64_6_scan.sv
// rtl/enc_64_6_scan.sv - captures a 64-bit vector and emits set-bit indices in ascending order
module enc_64_6_scan
   import enc_64_6_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   enc_64_6_scan_if.slave    bus
);

   state_t           state_q;
   state_t           state_d;
   logic [VEC_W-1:0] pending_q;
   logic [VEC_W-1:0] pending_d;
   logic [VEC_W-1:0] pending_clr;

   // encoder tree nets: 16 leaves over nibbles, 4 mids over leaf flags, 1 top
   logic [1:0]       leaf_idx [16];
   logic [15:0]      leaf_any;
   logic [1:0]       mid_idx  [4];
   logic [3:0]       mid_any;
   logic [1:0]       top_idx;
   logic             top_any;
   logic [1:0]       mid_sel;
   logic [1:0]       leaf_sel;
   logic [IDX_W-1:0] enc_idx;

   logic             scan_active;
   logic             beat_last;

   genvar g;

   for (g = 0; g < 16; g++) begin : g_leaf
      enc_4_2 u_leaf (
         .vec (pending_q[4*g +: 4]),
         .idx (leaf_idx[g]),
         .any (leaf_any[g])
      );
   end

   for (g = 0; g < 4; g++) begin : g_mid
      enc_4_2 u_mid (
         .vec (leaf_any[4*g +: 4]),
         .idx (mid_idx[g]),
         .any (mid_any[g])
      );
   end

   enc_4_2 u_top (
      .vec (mid_any),
      .idx (top_idx),
      .any (top_any)
   );

   // follow the winning branch down the tree; index bits are top:mid:leaf
   always_comb begin
      mid_sel  = mid_idx[top_idx];
      leaf_sel = leaf_idx[{top_idx, mid_sel}];
      enc_idx  = {top_idx, mid_sel, leaf_sel};
   end

   // pending with the currently presented bit removed; empty means this is the last beat
   always_comb begin
      pending_clr          = pending_q;
      pending_clr[enc_idx] = 1'b0;
   end

   assign scan_active   = (state_q == SCAN);
   assign beat_last     = scan_active && (pending_clr == '0);

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = scan_active;
   assign bus.out_idx   = enc_idx;
   assign bus.out_last  = beat_last;
   assign bus.out_empty = scan_active && !top_any;

   // state and pending vector registers; reset drops any beats still queued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   // capture in IDLE, retire one bit per accepted beat in SCAN
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               pending_d = bus.in_vec;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (bus.out_ready) begin
               pending_d = pending_clr;
               if (beat_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_enc_64_6_scan.sv
// tb/tb_enc_64_6_scan.sv - self-checking bench for enc_64_6_scan
module tb_enc_64_6_scan;
   import enc_64_6_scan_pkg::*;

   typedef struct {
      int idx;
      bit last;
      bit empty;
   } beat_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b1;
   int    checks   = 0;
   int    failures = 0;
   beat_t exp_q[$];

   enc_64_6_scan_if bus ();

   enc_64_6_scan dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected beats: every set bit in ascending order, or one empty beat for a zero vector
   task automatic build_model(input logic [63:0] vec);
      beat_t b;
      exp_q.delete();
      if (vec == 64'd0) begin
         b.idx = 0; b.last = 1'b1; b.empty = 1'b1;
         exp_q.push_back(b);
      end else begin
         for (int i = 0; i < 64; i++) begin
            if (vec[i]) begin
               b.idx = i; b.last = 1'b0; b.empty = 1'b0;
               exp_q.push_back(b);
            end
         end
         exp_q[exp_q.size()-1].last = 1'b1;
      end
   endtask

   // mode 0: always ready, 1: ready toggles starting low, 2: random ready
   task automatic run_vector(input logic [63:0] vec, input int mode);
      int    guard;
      bit    rdy;
      bit    tog;
      beat_t b;
      build_model(vec);
      check("idle_before_accept", 64'(bus.in_ready), 64'(1));
      bus.in_valid = 1'b1;
      bus.in_vec   = vec;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_vec   = {$urandom, $urandom};
      check("first_beat_latency", 64'(bus.out_valid), 64'(1));
      guard = 0;
      tog   = 1'b0;
      while (exp_q.size() > 0 && guard < 1000) begin
         b = exp_q[0];
         check("beat_valid", 64'(bus.out_valid), 64'(1));
         check("beat_in_ready_low", 64'(bus.in_ready), 64'(0));
         check("beat_idx", 64'(bus.out_idx), 64'(b.idx));
         check("beat_last", 64'(bus.out_last), 64'(b.last));
         check("beat_empty", 64'(bus.out_empty), 64'(b.empty));
         case (mode)
            0:       rdy = 1'b1;
            1:       begin rdy = tog; tog = ~tog; end
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bus.out_ready = rdy;
         @(negedge clk);
         if (rdy) void'(exp_q.pop_front());
         guard++;
      end
      check("all_beats_seen", 64'(exp_q.size()), 64'(0));
      bus.out_ready = 1'b0;
      check("end_out_valid_low", 64'(bus.out_valid), 64'(0));
      check("end_in_ready_high", 64'(bus.in_ready), 64'(1));
   endtask

   initial begin
      logic [63:0] v;
      int          pick;

      bus.in_valid  = 1'b0;
      bus.in_vec    = 64'd0;
      bus.out_ready = 1'b0;

      // reset asserted before any clock edge
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_idx", 64'(bus.out_idx), 64'(0));
      check("rst_out_last", 64'(bus.out_last), 64'(0));
      check("rst_out_empty", 64'(bus.out_empty), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", 64'(bus.out_valid), 64'(0));

      // directed vectors
      run_vector(64'h1, 0);
      run_vector(64'h8000_0000_0000_0001, 0);
      run_vector(64'h0, 0);
      run_vector(64'h0, 1);
      run_vector({64{1'b1}}, 1);
      run_vector(64'h8000_0000_0000_0000, 2);

      // reset in the middle of a scan
      bus.in_valid = 1'b1;
      bus.in_vec   = 64'hF0;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("f0_idx4", 64'(bus.out_idx), 64'(4));
      @(negedge clk);
      check("f0_idx5", 64'(bus.out_idx), 64'(5));
      @(negedge clk);
      check("f0_idx6_pending", 64'(bus.out_idx), 64'(6));
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("async_rst_out_idx", 64'(bus.out_idx), 64'(0));
      check("async_rst_out_last", 64'(bus.out_last), 64'(0));
      check("async_rst_out_empty", 64'(bus.out_empty), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_beat_after_rst", 64'(bus.out_valid), 64'(0));
      end
      bus.out_ready = 1'b0;

      // second vector held on in_valid during a scan
      bus.in_valid = 1'b1;
      bus.in_vec   = 64'h3;
      @(negedge clk);
      bus.in_vec    = 64'h10;
      bus.out_ready = 1'b1;
      check("hold_idx0", 64'(bus.out_idx), 64'(0));
      check("hold_last0", 64'(bus.out_last), 64'(0));
      check("hold_in_ready0", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      check("hold_idx1", 64'(bus.out_idx), 64'(1));
      check("hold_last1", 64'(bus.out_last), 64'(1));
      check("hold_in_ready_still0", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      check("gap_out_valid", 64'(bus.out_valid), 64'(0));
      check("gap_in_ready", 64'(bus.in_ready), 64'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("second_valid", 64'(bus.out_valid), 64'(1));
      check("second_idx4", 64'(bus.out_idx), 64'(4));
      check("second_last", 64'(bus.out_last), 64'(1));
      check("second_empty", 64'(bus.out_empty), 64'(0));
      @(negedge clk);
      check("second_done", 64'(bus.out_valid), 64'(0));
      bus.out_ready = 1'b0;

      // randomized vectors of varying density with random backpressure
      for (int r = 0; r < 12; r++) begin
         pick = int'($urandom_range(0, 3));
         case (pick)
            0:       v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            1:       v = {$urandom, $urandom} | {$urandom, $urandom};
            2:       v = 64'h1 << $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
         endcase
         run_vector(v, 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
